// File: rtl/risc_lram_arb_pkg.sv
//------------------------------------------------------------------------------
// risc_lram_arb_pkg: shared owner/state encodings for the local SRAM arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package risc_lram_arb_pkg;

  localparam int STARVE_MAX_DEFAULT = 4;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_EXT  = 2'd1;
  localparam owner_t OWN_LS   = 2'd2;
  localparam owner_t OWN_PF   = 2'd3;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_lram_starve.sv
//------------------------------------------------------------------------------
// risc_lram_starve: saturating count of denied prefetch cycles, force at MAX
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module risc_lram_starve
  import risc_lram_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic pf_req,
  input  logic pf_gnt,
  input  logic hold,
  output logic force_pf
);

  localparam int             CW      = cnt_width(MAX);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX);

  logic [CW-1:0] cnt;

  // While the external requester holds the lock the count is frozen, so a
  // prefetch that was close to starving keeps its place after the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!hold) begin
      if (pf_gnt || !pf_req) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign force_pf = (cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/risc_lram_arb.sv
//------------------------------------------------------------------------------
// risc_lram_arb: local SRAM arbiter for external bus, load/store and prefetch
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module risc_lram_arb
  import risc_lram_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              ext_req,
  input  logic              ext_lock,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ext_gnt,
  output logic              ls_gnt,
  output logic              pf_gnt,
  output logic              ext_rvalid,
  output logic              ls_rvalid,
  output logic              pf_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ls_wait,
  output logic              locked
);

  arb_state_t state;
  arb_state_t state_nxt;
  owner_t     rd_own;
  owner_t     rd_own_nxt;
  logic       force_pf;

  risc_lram_starve #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (sys_clk),
    .reset    (reset),
    .pf_req   (pf_req),
    .pf_gnt   (pf_gnt),
    .hold     (state == ST_LOCKED),
    .force_pf (force_pf)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ext_gnt   = 1'b0;
    ls_gnt    = 1'b0;
    pf_gnt    = 1'b0;
    if (!reset) begin
      case (state)
        ST_ARB: begin
          if (ext_req) begin
            ext_gnt = 1'b1;
          end else if (pf_req && force_pf) begin
            pf_gnt = 1'b1;
          end else if (ls_req) begin
            ls_gnt = 1'b1;
          end else if (pf_req) begin
            pf_gnt = 1'b1;
          end
          if (ext_gnt && ext_lock) begin
            state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // The release cycle still belongs to the external requester.
          ext_gnt = ext_req;
          if (!ext_lock) begin
            state_nxt = ST_ARB;
          end
        end
        default: begin
          state_nxt = ST_ARB;
        end
      endcase
    end
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    rd_own_nxt = OWN_NONE;
    if (ext_gnt) begin
      ram_we    = ext_we;
      ram_addr  = ext_addr;
      ram_wdata = ext_wdata;
      if (!ext_we) begin
        rd_own_nxt = OWN_EXT;
      end
    end else if (ls_gnt) begin
      ram_we    = ls_we;
      ram_addr  = ls_addr;
      ram_wdata = ls_wdata;
      if (!ls_we) begin
        rd_own_nxt = OWN_LS;
      end
    end else if (pf_gnt) begin
      ram_addr   = pf_addr;
      rd_own_nxt = OWN_PF;
    end
  end

  assign ram_cs = ext_gnt | ls_gnt | pf_gnt;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_own <= OWN_NONE;
    end else begin
      rd_own <= rd_own_nxt;
    end
  end

  // Gated with reset so a read issued just before reset never reports valid.
  assign ext_rvalid = (rd_own == OWN_EXT) & ~reset;
  assign ls_rvalid  = (rd_own == OWN_LS)  & ~reset;
  assign pf_rvalid  = (rd_own == OWN_PF)  & ~reset;
  assign rdata      = ram_rdata;

  assign ls_wait = ls_req & ~ls_gnt;
  assign locked  = (state == ST_LOCKED);

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge sys_clk) $onehot0({ext_gnt, ls_gnt, pf_gnt}));
  a_locked_excl : assert property (@(posedge sys_clk) locked |-> !(ls_gnt || pf_gnt));
`endif

endmodule

`default_nettype wire
